// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - key codes, coin values and state/key-class types for the vend controller
package vend_pkg;

  localparam logic [7:0] ASCII_N = 8'h6E;
  localparam logic [7:0] ASCII_D = 8'h64;
  localparam logic [7:0] ASCII_Q = 8'h71;
  localparam logic [7:0] ASCII_1 = 8'h31;
  localparam logic [7:0] ASCII_2 = 8'h32;
  localparam logic [7:0] ASCII_3 = 8'h33;
  localparam logic [7:0] ASCII_4 = 8'h34;
  localparam logic [7:0] ASCII_C = 8'h63;

  localparam logic [7:0] COIN_NICKEL  = 8'd5;
  localparam logic [7:0] COIN_DIME    = 8'd10;
  localparam logic [7:0] COIN_QUARTER = 8'd25;

  typedef enum logic [1:0] {
    IDLE,
    CREDIT,
    VEND,
    REFUND
  } vend_state_t;

  typedef enum logic [1:0] {
    COIN,
    SELECT,
    CANCEL,
    NONE
  } key_class_t;

endpackage

// File: rtl/vend_key_decoder.sv
// rtl/vend_key_decoder.sv - maps a received byte to key class, coin value and item index
module vend_key_decoder
  import vend_pkg::*;
(
  input  logic [7:0] rx_data,
  output logic [1:0] key_class,
  output logic [7:0] coin_value,
  output logic [1:0] item
);

  // '1'..'4' are 0x31..0x34, so the low two bits minus one give item 0..3
  assign item = rx_data[1:0] - 2'd1;

  always_comb begin
    key_class  = NONE;
    coin_value = '0;
    case (rx_data)
      ASCII_N: begin
        key_class  = COIN;
        coin_value = COIN_NICKEL;
      end
      ASCII_D: begin
        key_class  = COIN;
        coin_value = COIN_DIME;
      end
      ASCII_Q: begin
        key_class  = COIN;
        coin_value = COIN_QUARTER;
      end
      ASCII_1, ASCII_2, ASCII_3, ASCII_4: key_class = SELECT;
      ASCII_C: key_class = CANCEL;
      default: ;
    endcase
  end

endmodule

// File: rtl/vend_cmd_controller.sv
// rtl/vend_cmd_controller.sv - vend transaction sequencer driven by the UART receive byte stream
module vend_cmd_controller
  import vend_pkg::*;
#(
  parameter logic [7:0]  PRICE0         = 8'd50,
  parameter logic [7:0]  PRICE1         = 8'd75,
  parameter logic [7:0]  PRICE2         = 8'd100,
  parameter logic [7:0]  PRICE3         = 8'd125,
  parameter logic [7:0]  MAX_CREDIT     = 8'd200,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       dispense,
  output logic [1:0] item_id,
  output logic       change_valid,
  output logic [7:0] change_amount,
  output logic [7:0] credit,
  output logic       error,
  output logic       busy
);

  vend_state_t state, state_nx;
  logic [1:0]  sel_item, sel_item_nx;
  logic [31:0] timer, timer_nx;

  logic        dispense_nx, change_valid_nx, error_nx, busy_nx;
  logic [1:0]  item_id_nx;
  logic [7:0]  change_amount_nx, credit_nx;

  logic [1:0]  key_class;
  logic [7:0]  coin_value;
  logic [1:0]  key_item;
  logic [8:0]  coin_sum;
  logic [7:0]  key_price, sel_price;

  vend_key_decoder u_key_decoder (
    .rx_data    (rx_data),
    .key_class  (key_class),
    .coin_value (coin_value),
    .item       (key_item)
  );

  function automatic logic [7:0] price_of(input logic [1:0] idx);
    case (idx)
      2'd0:    price_of = PRICE0;
      2'd1:    price_of = PRICE1;
      2'd2:    price_of = PRICE2;
      default: price_of = PRICE3;
    endcase
  endfunction

  // Ninth bit keeps the ceiling compare honest when credit + coin passes 255
  assign coin_sum  = {1'b0, credit} + {1'b0, coin_value};
  assign key_price = price_of(key_item);
  assign sel_price = price_of(sel_item);

  always_comb begin
    state_nx         = state;
    sel_item_nx      = sel_item;
    timer_nx         = timer;
    credit_nx        = credit;
    item_id_nx       = item_id;
    change_amount_nx = change_amount;
    dispense_nx      = 1'b0;
    change_valid_nx  = 1'b0;
    error_nx         = 1'b0;

    case (state)
      IDLE: begin
        if (rx_valid) begin
          if (key_class == COIN) begin
            credit_nx = coin_value;
            timer_nx  = '0;
            state_nx  = CREDIT;
          end else if (key_class == SELECT) begin
            error_nx = 1'b1;
          end
        end
      end

      CREDIT: begin
        if (rx_valid) begin
          timer_nx = '0;
          case (key_class)
            COIN: begin
              if (coin_sum <= {1'b0, MAX_CREDIT}) credit_nx = coin_sum[7:0];
              else                                error_nx  = 1'b1;
            end
            SELECT: begin
              if (credit >= key_price) begin
                sel_item_nx = key_item;
                state_nx    = VEND;
              end else begin
                error_nx = 1'b1;
              end
            end
            CANCEL: begin
              change_valid_nx  = 1'b1;
              change_amount_nx = credit;
              credit_nx        = '0;
              state_nx         = REFUND;
            end
            default: ;
          endcase
        // A byte arriving on the expiry cycle takes the branch above instead
        end else if (timer == TIMEOUT_CYCLES - 32'd1) begin
          change_valid_nx  = 1'b1;
          change_amount_nx = credit;
          credit_nx        = '0;
          state_nx         = REFUND;
        end else begin
          timer_nx = timer + 32'd1;
        end
      end

      VEND: begin
        dispense_nx = 1'b1;
        item_id_nx  = sel_item;
        if (credit != sel_price) begin
          change_valid_nx  = 1'b1;
          change_amount_nx = credit - sel_price;
        end
        credit_nx = '0;
        state_nx  = IDLE;
      end

      // Refund pulse already went out on entry; this cycle only holds off rx
      REFUND: state_nx = IDLE;

      default: state_nx = IDLE;
    endcase

    busy_nx = (state_nx == VEND) || (state_nx == REFUND);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      sel_item      <= '0;
      timer         <= '0;
      dispense      <= 1'b0;
      item_id       <= '0;
      change_valid  <= 1'b0;
      change_amount <= '0;
      credit        <= '0;
      error         <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_nx;
      sel_item      <= sel_item_nx;
      timer         <= timer_nx;
      dispense      <= dispense_nx;
      item_id       <= item_id_nx;
      change_valid  <= change_valid_nx;
      change_amount <= change_amount_nx;
      credit        <= credit_nx;
      error         <= error_nx;
      busy          <= busy_nx;
    end
  end

endmodule

// File: tb/tb_vend_cmd_controller.sv
// tb/tb_vend_cmd_controller.sv - randomized scoreboard bench for vend_cmd_controller
module tb_vend_cmd_controller;

  localparam int TMO = 100;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       dispense, change_valid, error, busy;
  logic [1:0] item_id;
  logic [7:0] change_amount, credit;

  always #5 clk = ~clk;

  vend_cmd_controller #(.TIMEOUT_CYCLES(32'd100)) dut (
    .clk           (clk),
    .reset         (reset),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .dispense      (dispense),
    .item_id       (item_id),
    .change_valid  (change_valid),
    .change_amount (change_amount),
    .credit        (credit),
    .error         (error),
    .busy          (busy)
  );

  typedef struct {
    int edge_n;
    int disp;
    int item;
    int cv;
    int amt;
    int err;
  } ev_t;

  typedef struct {
    int edge_n;
    int cr;
    int bz;
  } tl_t;

  ev_t evq[$];
  tl_t tlq[$];
  int  checks = 0;
  int  failures = 0;
  int  edge_n = 0;
  bit  in_reset = 1'b1;

  int  m_credit = 0;
  int  m_last = 0;
  int  m_ignore = -1;
  int  prices[4] = '{50, 75, 100, 125};

  int  cur_cr = 0;
  int  cur_bz = 0;
  ev_t mx;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d edge=%0d", name, act, exp, edge_n);
    end
  endtask

  task automatic refund(input int e);
    evq.push_back('{e, 0, 0, 1, m_credit, 0});
    tlq.push_back('{e, 0, 1});
    tlq.push_back('{e + 1, 0, 0});
    m_ignore = e + 1;
    m_credit = 0;
  endtask

  // Transaction-level reference: credit balance, inactivity deadline and response edges
  task automatic model_step(input int e, input bit v, input logic [7:0] b);
    int val;
    int k;
    int diff;
    if (!(v && e != m_ignore)) begin
      if (m_credit > 0 && e == m_last + TMO) refund(e);
      return;
    end
    m_last = e;
    val = 0;
    if (b == 8'h6E) val = 5;
    if (b == 8'h64) val = 10;
    if (b == 8'h71) val = 25;
    if (val != 0) begin
      if (m_credit + val > 200) begin
        evq.push_back('{e, 0, 0, 0, 0, 1});
      end else begin
        m_credit += val;
        tlq.push_back('{e, m_credit, 0});
      end
    end else if (b >= 8'h31 && b <= 8'h34) begin
      k = int'(b) - 'h31;
      if (m_credit >= prices[k]) begin
        diff = m_credit - prices[k];
        evq.push_back('{e + 1, 1, k, (diff != 0) ? 1 : 0, diff, 0});
        tlq.push_back('{e, m_credit, 1});
        tlq.push_back('{e + 1, 0, 0});
        m_ignore = e + 1;
        m_credit = 0;
      end else begin
        evq.push_back('{e, 0, 0, 0, 0, 1});
      end
    end else if (b == 8'h63 && m_credit > 0) begin
      refund(e);
    end
  endtask

  always @(negedge clk) begin
    if (!in_reset) begin
      while (tlq.size() > 0 && tlq[0].edge_n <= edge_n) begin
        cur_cr = tlq[0].cr;
        cur_bz = tlq[0].bz;
        void'(tlq.pop_front());
      end
      chk("credit", int'(credit), cur_cr);
      chk("busy", int'(busy), cur_bz);
      while (evq.size() > 0 && evq[0].edge_n < edge_n) begin
        chk("missed_event_edge", edge_n, evq[0].edge_n);
        void'(evq.pop_front());
      end
      if (dispense || change_valid || error) begin
        if (evq.size() > 0 && evq[0].edge_n == edge_n) begin
          mx = evq.pop_front();
          chk("dispense", int'(dispense), mx.disp);
          chk("change_valid", int'(change_valid), mx.cv);
          chk("error", int'(error), mx.err);
          if (mx.disp != 0) chk("item_id", int'(item_id), mx.item);
          if (mx.cv != 0) chk("change_amount", int'(change_amount), mx.amt);
        end else begin
          chk("unexpected_pulse", int'({dispense, change_valid, error}), 0);
        end
      end
    end
  end

  task automatic cyc(input bit v, input logic [7:0] b);
    @(posedge clk);
    #1;
    rx_valid = v;
    rx_data  = v ? b : 8'($urandom);
    model_step(edge_n + 1, v, b);
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    cyc(1'b1, b);
    repeat (gap) cyc(1'b0, 8'h00);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_dispense"}, int'(dispense), 0);
    chk({tag, "_item_id"}, int'(item_id), 0);
    chk({tag, "_change_valid"}, int'(change_valid), 0);
    chk({tag, "_change_amount"}, int'(change_amount), 0);
    chk({tag, "_credit"}, int'(credit), 0);
    chk({tag, "_error"}, int'(error), 0);
    chk({tag, "_busy"}, int'(busy), 0);
  endtask

  task automatic model_reset();
    evq.delete();
    tlq.delete();
    tlq.push_back('{0, 0, 0});
    m_credit = 0;
    m_last   = 0;
    m_ignore = -1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] keys[10];
    int         r;
    int         gap;
    keys = '{8'h6E, 8'h64, 8'h71, 8'h71, 8'h31, 8'h32, 8'h33, 8'h34, 8'h63, 8'h78};

    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    reset = 1'b1;
    model_reset();
    in_reset = 1'b0;

    send(8'h71, 1); send(8'h71, 1); send(8'h31, 3);
    repeat (4) send(8'h71, 1);
    send(8'h6E, 1); send(8'h32, 3);
    send(8'h64, 1); send(8'h33, 1); send(8'h63, 3);
    repeat (8) send(8'h71, 1);
    send(8'h6E, 1); send(8'h63, 3);

    send(8'h64, TMO + 5);
    send(8'h64, TMO - 1);
    send(8'h6E, 2);
    send(8'h63, 3);

    for (int i = 0; i < 300; i++) begin
      r   = $urandom_range(0, 19);
      gap = (r == 0) ? $urandom_range(TMO - 3, TMO + 3) : $urandom_range(0, 3);
      r   = $urandom_range(0, 11);
      if (r >= 10) send(8'($urandom), gap);
      else         send(keys[r], gap);
    end

    repeat (TMO + 10) cyc(1'b0, 8'h00);
    send(8'h71, 10);
    @(posedge clk);
    #3;
    reset    = 1'b0;
    in_reset = 1'b1;
    #1;
    check_outputs_zero("midreset");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
    in_reset = 1'b0;
    send(8'h6E, 1);
    send(8'h31, 2);

    repeat (TMO + 30) cyc(1'b0, 8'h00);
    chk("pending_events", evq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
